// File: rtl/lsu_pkg.sv
// lsu_pkg: memory operation encodings shared by decode, execute and the load/store unit
package lsu_pkg;
    localparam int LSU_OP_W = 4;
    // bit 3 = store, bit 2 = unsigned load, bits [1:0] = access size (0 byte, 1 half, 2 word)
    localparam logic [LSU_OP_W-1:0] LSU_LB  = 4'b0000;
    localparam logic [LSU_OP_W-1:0] LSU_LH  = 4'b0001;
    localparam logic [LSU_OP_W-1:0] LSU_LW  = 4'b0010;
    localparam logic [LSU_OP_W-1:0] LSU_LBU = 4'b0100;
    localparam logic [LSU_OP_W-1:0] LSU_LHU = 4'b0101;
    localparam logic [LSU_OP_W-1:0] LSU_SB  = 4'b1000;
    localparam logic [LSU_OP_W-1:0] LSU_SH  = 4'b1001;
    localparam logic [LSU_OP_W-1:0] LSU_SW  = 4'b1010;

    function automatic logic lsu_op_valid(input logic [LSU_OP_W-1:0] op);
        return op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW};
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: alignment check, store lane replication/strobes and load extraction
module lsu_align
    import lsu_pkg::*;
(
    input  logic [LSU_OP_W-1:0] i_op,
    input  logic [1:0]          i_addr,
    input  logic [31:0]         i_wdata,
    input  logic [31:0]         i_rdata,
    output logic                o_misalign,
    output logic [3:0]          o_wstrb,
    output logic [31:0]         o_wdata,
    output logic [31:0]         o_rdata
);
    logic [1:0]  w_size;
    logic        w_store;
    logic        w_uns;
    logic [31:0] w_shift;

    // decode size/sign and derive lane data in both directions
    always_comb begin
        w_size     = i_op[1:0];
        w_store    = i_op[3];
        w_uns      = i_op[2];
        w_shift    = i_rdata >> {i_addr, 3'b000};
        o_misalign = !lsu_op_valid(i_op) || (w_size == 2'd1 && i_addr[0]) || (w_size == 2'd2 && i_addr != 2'd0);
        o_wstrb    = !w_store ? 4'b0000 :
                     w_size == 2'd0 ? 4'b0001 << i_addr :
                     w_size == 2'd1 ? 4'b0011 << i_addr : 4'b1111;
        o_wdata    = w_size == 2'd0 ? {4{i_wdata[7:0]}} :
                     w_size == 2'd1 ? {2{i_wdata[15:0]}} : i_wdata;
        o_rdata    = w_size == 2'd0 ? {{24{~w_uns & w_shift[7]}}, w_shift[7:0]} :
                     w_size == 2'd1 ? {{16{~w_uns & w_shift[15]}}, w_shift[15:0]} : w_shift;
    end
endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit between execute stage and data-memory bus
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [LSU_OP_W-1:0] i_req_op,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic [DATA_W-1:0]   i_req_wdata,
    output logic                o_resp_valid,
    output logic [DATA_W-1:0]   o_resp_rdata,
    output logic                o_resp_err,
    output logic                o_mem_req_valid,
    input  logic                i_mem_req_ready,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic                o_mem_wen,
    output logic [3:0]          o_mem_wstrb,
    output logic [DATA_W-1:0]   o_mem_wdata,
    input  logic                i_mem_resp_valid,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    input  logic                i_mem_resp_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]          r_state;
    logic                r_alive;
    logic [LSU_OP_W-1:0] r_op;
    logic [1:0]          r_alo;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_wen;
    logic [3:0]          r_mem_wstrb;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic [LSU_OP_W-1:0] w_op;
    logic [1:0]          w_alo;
    logic                w_misalign;
    logic [3:0]          w_wstrb;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_rdata;

    // align unit sees the incoming request while idle, the latched one afterwards
    assign w_op  = r_state == S_IDLE ? i_req_op : r_op;
    assign w_alo = r_state == S_IDLE ? i_req_addr[1:0] : r_alo;

    lsu_align u_align (
        .i_op       (w_op),
        .i_addr     (w_alo),
        .i_wdata    (i_req_wdata),
        .i_rdata    (i_mem_rdata),
        .o_misalign (w_misalign),
        .o_wstrb    (w_wstrb),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata)
    );

    assign o_req_ready     = r_alive && r_state == S_IDLE;
    assign o_resp_valid    = r_state == S_RESP;
    assign o_resp_rdata    = r_rdata;
    assign o_resp_err      = r_err;
    assign o_mem_req_valid = r_state == S_REQ;
    assign o_mem_addr      = r_mem_addr;
    assign o_mem_wen       = r_mem_wen;
    assign o_mem_wstrb     = r_mem_wstrb;
    assign o_mem_wdata     = r_mem_wdata;

    // request FSM: accept, drive bus, await response, pulse completion
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_alive     <= 1'b0;
            r_op        <= '0;
            r_alo       <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wen   <= 1'b0;
            r_mem_wstrb <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                S_IDLE: if (r_alive && i_req_valid) begin
                    r_op  <= i_req_op;
                    r_alo <= i_req_addr[1:0];
                    if (w_misalign) begin
                        r_state <= S_RESP;
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_state     <= S_REQ;
                        r_mem_addr  <= {i_req_addr[ADDR_W-1:2], 2'b00};
                        r_mem_wen   <= i_req_op[3];
                        r_mem_wstrb <= w_wstrb;
                        r_mem_wdata <= w_wdata;
                    end
                end
                S_REQ: if (i_mem_req_ready) r_state <= S_WAIT;
                S_WAIT: if (i_mem_resp_valid) begin
                    r_state <= S_RESP;
                    r_rdata <= (i_mem_resp_err || r_op[3]) ? '0 : w_rdata;
                    r_err   <= i_mem_resp_err;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed scoreboard bench for the load/store unit
module tb_lsu;
    import lsu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_resp_err = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    logic [32:0] sb_q[$];

    lsu dut (
        .clock           (clock),
        .reset           (reset),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_req_op        (req_op),
        .i_req_addr      (req_addr),
        .i_req_wdata     (req_wdata),
        .o_resp_valid    (resp_valid),
        .o_resp_rdata    (resp_rdata),
        .o_resp_err      (resp_err),
        .o_mem_req_valid (mem_req_valid),
        .i_mem_req_ready (mem_req_ready),
        .o_mem_addr      (mem_addr),
        .o_mem_wen       (mem_wen),
        .o_mem_wstrb     (mem_wstrb),
        .o_mem_wdata     (mem_wdata),
        .i_mem_resp_valid(mem_resp_valid),
        .i_mem_rdata     (mem_rdata),
        .i_mem_resp_err  (mem_resp_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_resp(input string tag);
        logic [32:0] e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s observed=response expected=empty_scoreboard", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
            chk({tag, "_rdata"}, resp_rdata, e[31:0]);
            chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, e[32]});
        end
    endtask

    // full transaction: accept, optional bus phase with stalls, completion check
    task automatic txn(input string tag, input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic mis, input logic [31:0] e_addr, input logic e_wen, input logic [3:0] e_strb,
                       input logic [31:0] e_wdata, input logic [31:0] bus_rd, input logic bus_err,
                       input int rdy_dly, input int rsp_dly, input logic [31:0] e_rdata, input logic e_err);
        chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        sb_q.push_back({e_err, e_rdata});
        tick();
        req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        if (mis) begin
            chk({tag, "_noreq"}, {31'b0, mem_req_valid}, 32'd0);
        end else begin
            for (int i = 0; i <= rdy_dly; i++) begin
                chk({tag, "_mreqv"}, {31'b0, mem_req_valid}, 32'd1);
                chk({tag, "_maddr"}, mem_addr, e_addr);
                chk({tag, "_mwen"}, {31'b0, mem_wen}, {31'b0, e_wen});
                chk({tag, "_mstrb"}, {28'b0, mem_wstrb}, {28'b0, e_strb});
                if (e_wen) chk({tag, "_mwdata"}, mem_wdata, e_wdata);
                if (i == rdy_dly) mem_req_ready = 1'b1;
                tick();
            end
            mem_req_ready = 1'b0;
            for (int i = 0; i <= rsp_dly; i++) begin
                chk({tag, "_wait"}, {30'b0, resp_valid, mem_req_valid}, 32'd0);
                if (i == rsp_dly) begin
                    mem_resp_valid = 1'b1; mem_rdata = bus_rd; mem_resp_err = bus_err;
                end
                tick();
            end
            mem_resp_valid = 1'b0; mem_rdata = '0; mem_resp_err = 1'b0;
        end
        chk_resp(tag);
        tick();
        chk({tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_outs", {resp_valid, resp_err, mem_req_valid, mem_wen, mem_wstrb, 24'b0}, 32'd0);
        chk("rst_data", resp_rdata | mem_addr | mem_wdata, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("idle_ready", {31'b0, req_ready}, 32'd1);
        txn("lb",   LSU_LB,  32'h1003, 32'h0, 1'b0, 32'h1000, 1'b0, 4'b0000, 32'h0,
            32'h80FF_0000, 1'b0, 0, 0, 32'hFFFF_FF80, 1'b0);
        txn("lhu",  LSU_LHU, 32'h2002, 32'h0, 1'b0, 32'h2000, 1'b0, 4'b0000, 32'h0,
            32'hBEEF_1234, 1'b0, 0, 0, 32'h0000_BEEF, 1'b0);
        txn("sb",   LSU_SB,  32'h3001, 32'h0000_00AB, 1'b0, 32'h3000, 1'b1, 4'b0010, 32'hABAB_ABAB,
            32'h1234_5678, 1'b0, 0, 1, 32'h0, 1'b0);
        txn("swmis", LSU_SW, 32'h4002, 32'h1111_1111, 1'b1, 32'h0, 1'b0, 4'b0, 32'h0,
            32'h0, 1'b0, 0, 0, 32'h0, 1'b1);
        txn("lwerr", LSU_LW, 32'h5004, 32'h0, 1'b0, 32'h5004, 1'b0, 4'b0000, 32'h0,
            32'hCAFE_F00D, 1'b1, 3, 5, 32'h0, 1'b1);
        txn("sh",   LSU_SH,  32'h6002, 32'h1234_CDEF, 1'b0, 32'h6000, 1'b1, 4'b1100, 32'hCDEF_CDEF,
            32'h0, 1'b0, 1, 0, 32'h0, 1'b0);
        txn("lh",   LSU_LH,  32'h7000, 32'h0, 1'b0, 32'h7000, 1'b0, 4'b0000, 32'h0,
            32'h0000_8001, 1'b0, 0, 2, 32'hFFFF_8001, 1'b0);
        txn("lbu",  LSU_LBU, 32'h7102, 32'h0, 1'b0, 32'h7100, 1'b0, 4'b0000, 32'h0,
            32'h00F0_0000, 1'b0, 0, 0, 32'h0000_00F0, 1'b0);
        txn("lhmis", LSU_LH, 32'h7201, 32'h0, 1'b1, 32'h0, 1'b0, 4'b0, 32'h0,
            32'h0, 1'b0, 0, 0, 32'h0, 1'b1);
        txn("badop", 4'b0011, 32'h7300, 32'h0, 1'b1, 32'h0, 1'b0, 4'b0, 32'h0,
            32'h0, 1'b0, 0, 0, 32'h0, 1'b1);
        // reset while waiting for the bus response; the late response must be dropped
        req_valid = 1'b1; req_op = LSU_LW; req_addr = 32'h8000;
        tick();
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", {31'b0, req_ready}, 32'd0);
        chk("mid_rst_outs", {resp_valid, mem_req_valid, mem_wen, mem_wstrb, 25'b0}, 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        mem_resp_valid = 1'b1; mem_rdata = 32'h1357_9BDF;
        tick();
        mem_resp_valid = 1'b0; mem_rdata = '0;
        chk("stray_drop", {31'b0, resp_valid}, 32'd0);
        tick();
        chk("post_rst_idle", {30'b0, req_ready, resp_valid}, 32'd2);
        txn("lw",   LSU_LW,  32'h9000, 32'h0, 1'b0, 32'h9000, 1'b0, 4'b0000, 32'h0,
            32'hDEAD_BEEF, 1'b0, 0, 0, 32'hDEAD_BEEF, 1'b0);
        n_checks++;
        assert (sb_q.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_empty observed=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
